// File: rtl/fetch_pkg.sv
// Shared constants, the fetch word record and branch/jump target helpers
// for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  // Field positions of the I-type immediate and J-type target.
  localparam int IMM_MSB = 15;
  localparam int TGT_MSB = 25;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_word_t;

  function automatic logic [31:0] jump_dest(input logic [31:0] pc_p4,
                                            input logic [31:0] instr);
    return {pc_p4[31:28], instr[TGT_MSB:0], 2'b00};
  endfunction

  function automatic logic [31:0] branch_dest(input logic [31:0] pc_p4,
                                              input logic [31:0] instr);
    return pc_p4 + {{14{instr[IMM_MSB]}}, instr[IMM_MSB:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and
// instruction memory (slave).
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/fetch.sv
// MIPS instruction-fetch stage: fetch PC, single outstanding imem request,
// one-entry skid buffer, IF/ID register and delay-slot redirect handling.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump_branch,
  input  logic        jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_pc,
  fetch_if.master     imem,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic        valid_id
);

  logic        run;
  logic [31:0] fpc;
  logic        out_pend;
  logic [31:0] out_pc;
  logic        skid_v;
  fetch_word_t skid;
  logic        redir_pend;
  logic [31:0] redir_tgt;

  logic        id_acc;
  logic        resp;
  logic        grant;
  logic        fire;
  logic        case_a;
  logic        case_b;
  logic [31:0] pc_id_p4;
  logic [31:0] pc_id_p8;
  logic [31:0] target;

  assign id_acc = ~valid_id | ~stall;
  // A response only counts while a request is outstanding; strays are dropped.
  assign resp   = imem.imem_rvalid & out_pend;

  assign imem.imem_req = run & ~skid_v & (~out_pend | (resp & id_acc));
  assign grant         = imem.imem_req & imem.imem_gnt;

  assign pc_id_p4 = pc_id + 32'd4;
  assign pc_id_p8 = pc_id + 32'd8;

  assign fire   = valid_id & ~stall & (jump_reg | jump_target | jump_branch);
  assign case_a = fire & (fpc == pc_id_p4);
  assign case_b = fire & (fpc == pc_id_p8);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    target = branch_dest(pc_id_p4, instr_id);
    if (jump_reg) begin
      target = jr_pc;
    end else if (jump_target) begin
      target = jump_dest(pc_id_p4, instr_id);
    end
  end

  // Delay slot already in flight: the target goes out on the bus right now.
  assign imem.imem_addr = case_b ? target : fpc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run        <= 1'b0;
      fpc        <= RESET_PC;
      redir_pend <= 1'b0;
      redir_tgt  <= 32'h0;
      out_pend   <= 1'b0;
      out_pc     <= 32'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      run <= 1'b1;
      if (case_b) begin
        fpc <= grant ? target + 32'd4 : target;
      end else if (case_a) begin
        if (grant) begin
          fpc <= target;
        end else begin
          redir_pend <= 1'b1;
          redir_tgt  <= target;
        end
      end else if (grant) begin
        if (redir_pend) begin
          fpc        <= redir_tgt;
          redir_pend <= 1'b0;
        end else begin
          fpc <= fpc + 32'd4;
        end
      end

      if (grant) begin
        out_pend <= 1'b1;
        out_pc   <= imem.imem_addr;
      end else if (resp) begin
        out_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_v   <= 1'b0;
      // NOTE: the skid payload is reset too so no X can ever reach ID.
      skid     <= '0;
      valid_id <= 1'b0;
      pc_id    <= 32'h0;
      instr_id <= NOP_INSTR;
    end else begin
      if (resp && !id_acc) begin
        skid_v <= 1'b1;
        skid   <= '{pc: out_pc, instr: imem.imem_rdata};
      end

      // Skid buffer and response never coexist, since a full skid blocks requests.
      if (id_acc) begin
        if (skid_v) begin
          valid_id <= 1'b1;
          pc_id    <= skid.pc;
          instr_id <= skid.instr;
          skid_v   <= 1'b0;
        end else if (resp) begin
          valid_id <= 1'b1;
          pc_id    <= out_pc;
          instr_id <= imem.imem_rdata;
        end else begin
          valid_id <= 1'b0;
          instr_id <= NOP_INSTR;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: per-cycle vector table covering streaming,
// beq, jr (deferred redirect), stall/skid, j with delay slot buffered and
// PC wrap-around, plus hand sequences for reset and reset mid-request.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        jump_branch;
  logic        jump_target;
  logic        jump_reg;
  logic [31:0] jr_pc;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        valid_id;

  fetch_if bus ();

  fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .jump_branch (jump_branch),
    .jump_target (jump_target),
    .jump_reg    (jump_reg),
    .jr_pc       (jr_pc),
    .imem        (bus),
    .pc_id       (pc_id),
    .instr_id    (instr_id),
    .valid_id    (valid_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Grant seen in the current cycle; answered with data in the next one.
  logic        mg;
  logic [31:0] ma;

  typedef struct packed {
    logic        stall;
    logic        gnt;
    logic        jb;
    logic        jt;
    logic        jr;
    logic [31:0] jr_pc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  localparam int NVEC = 35;
  vec_t vec [NVEC];

  function automatic vec_t mk(input logic s, input logic g, input logic jb,
                              input logic jt, input logic jr, input logic [31:0] jp,
                              input logic rq, input logic [31:0] ad,
                              input logic v, input logic [31:0] pc);
    vec_t r;
    r = '{stall: s, gnt: g, jb: jb, jt: jt, jr: jr, jr_pc: jp,
          req: rq, addr: ad, valid: v, pc: pc};
    return r;
  endfunction

  // Instruction memory image: beq +3 at 0x00400010, j 0x40 at 0x00400114.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0040_0010: return 32'h1000_0003;
      32'h0040_0114: return 32'h0800_0040;
      default:       return a ^ 32'h2400_0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic mem_drive();
    bus.imem_rvalid = mg;
    bus.imem_rdata  = mg ? mem_word(ma) : 32'h0;
  endtask

  task automatic sample_grant();
    mg = bus.imem_req & bus.imem_gnt;
    ma = bus.imem_addr;
  endtask

  initial begin
    //           st g jb jt jr jr_pc          req addr           v  pc
    vec[0]  = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0040_0000, 0, 32'h0000_0000);
    vec[1]  = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0040_0004, 0, 32'h0000_0000);
    vec[2]  = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0040_0008, 1, 32'h0040_0000);
    vec[3]  = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0040_000C, 1, 32'h0040_0004);
    vec[4]  = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0040_0010, 1, 32'h0040_0008);
    vec[5]  = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0040_0014, 1, 32'h0040_000C);
    vec[6]  = mk(0, 1, 1, 0, 0, 32'h0,         1, 32'h0040_0020, 1, 32'h0040_0010);
    vec[7]  = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0040_0024, 1, 32'h0040_0014);
    vec[8]  = mk(0, 0, 0, 0, 0, 32'h0,         1, 32'h0040_0028, 1, 32'h0040_0020);
    vec[9]  = mk(0, 0, 0, 0, 1, 32'h0040_0100, 1, 32'h0040_0028, 1, 32'h0040_0024);
    vec[10] = mk(0, 0, 0, 0, 0, 32'h0,         1, 32'h0040_0028, 0, 32'h0040_0024);
    vec[11] = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0040_0028, 0, 32'h0040_0024);
    vec[12] = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0040_0100, 0, 32'h0040_0024);
    vec[13] = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0040_0104, 1, 32'h0040_0028);
    vec[14] = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0040_0108, 1, 32'h0040_0100);
    vec[15] = mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0040_010C, 1, 32'h0040_0104);
    vec[16] = mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0040_010C, 1, 32'h0040_0104);
    vec[17] = mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0040_010C, 1, 32'h0040_0104);
    vec[18] = mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0040_010C, 1, 32'h0040_0104);
    vec[19] = mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h0040_010C, 1, 32'h0040_0104);
    vec[20] = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0040_010C, 1, 32'h0040_0108);
    vec[21] = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0040_0110, 0, 32'h0040_0108);
    vec[22] = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0040_0114, 1, 32'h0040_010C);
    vec[23] = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0040_0118, 1, 32'h0040_0110);
    vec[24] = mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0040_011C, 1, 32'h0040_0114);
    vec[25] = mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0040_011C, 1, 32'h0040_0114);
    vec[26] = mk(0, 1, 0, 1, 0, 32'h0,         0, 32'h0000_0100, 1, 32'h0040_0114);
    vec[27] = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0000_0100, 1, 32'h0040_0118);
    vec[28] = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0000_0104, 0, 32'h0040_0118);
    vec[29] = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0000_0108, 1, 32'h0000_0100);
    vec[30] = mk(0, 1, 0, 0, 1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 1, 32'h0000_0104);
    vec[31] = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 32'h0000_0108);
    vec[32] = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0000_0000, 1, 32'hFFFF_FFF8);
    vec[33] = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0000_0004, 1, 32'hFFFF_FFFC);
    vec[34] = mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0000);

    // Reset state.
    rst_n           = 1'b0;
    stall           = 1'b0;
    jump_branch     = 1'b0;
    jump_target     = 1'b0;
    jump_reg        = 1'b0;
    jr_pc           = 32'h0;
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    mg              = 1'b0;
    ma              = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req",   {31'h0, bus.imem_req}, 32'h0);
    check("rst addr",  bus.imem_addr, 32'h0040_0000);
    check("rst valid", {31'h0, valid_id}, 32'h0);
    check("rst pc",    pc_id, 32'h0);
    check("rst instr", instr_id, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      mem_drive();
      stall        = vec[i].stall;
      bus.imem_gnt = vec[i].gnt;
      jump_branch  = vec[i].jb;
      jump_target  = vec[i].jt;
      jump_reg     = vec[i].jr;
      jr_pc        = vec[i].jr_pc;
      @(negedge clk);
      check($sformatf("c%0d req", i),   {31'h0, bus.imem_req}, {31'h0, vec[i].req});
      check($sformatf("c%0d addr", i),  bus.imem_addr, vec[i].addr);
      check($sformatf("c%0d valid", i), {31'h0, valid_id}, {31'h0, vec[i].valid});
      check($sformatf("c%0d pc", i),    pc_id, vec[i].pc);
      check($sformatf("c%0d instr", i), instr_id,
            vec[i].valid ? mem_word(vec[i].pc) : 32'h0);
      if (i == 10) check("jr redir_pend set",     {31'h0, dut.redir_pend}, 32'h1);
      if (i == 12) check("jr redir_pend cleared", {31'h0, dut.redir_pend}, 32'h0);
      if (i == 17) begin
        check("stall skid full", {31'h0, dut.skid_v}, 32'h1);
        check("stall skid pc",   dut.skid.pc, 32'h0040_0108);
      end
      if (i == 20) check("stall skid drained", {31'h0, dut.skid_v}, 32'h0);
      sample_grant();
      @(posedge clk);
      #1;
    end

    // Reset mid-request, then a stray rvalid while nothing is outstanding.
    mem_drive();
    stall       = 1'b0;
    jump_branch = 1'b0;
    jump_target = 1'b0;
    jump_reg    = 1'b0;
    check("midreq out_pend before", {31'h0, dut.out_pend}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreq valid",    {31'h0, valid_id}, 32'h0);
    check("midreq pc",       pc_id, 32'h0);
    check("midreq instr",    instr_id, 32'h0);
    check("midreq req",      {31'h0, bus.imem_req}, 32'h0);
    check("midreq addr",     bus.imem_addr, 32'h0040_0000);
    check("midreq out_pend", {31'h0, dut.out_pend}, 32'h0);
    mg = 1'b0;
    @(posedge clk);
    #1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n        = 1'b1;
    bus.imem_gnt = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("restart req",  {31'h0, bus.imem_req}, 32'h1);
    check("restart addr", bus.imem_addr, 32'h0040_0000);
    @(posedge clk);
    #1;
    check("stray ignored valid", {31'h0, valid_id}, 32'h0);
    check("stray ignored pc",    pc_id, 32'h0);
    bus.imem_rvalid = 1'b0;
    bus.imem_gnt    = 1'b1;
    @(negedge clk);
    check("restart addr2", bus.imem_addr, 32'h0040_0000);
    sample_grant();
    @(posedge clk);
    #1;
    mem_drive();
    @(negedge clk);
    check("restart bubble", {31'h0, valid_id}, 32'h0);
    sample_grant();
    @(posedge clk);
    #1;
    mem_drive();
    @(negedge clk);
    check("restart valid", {31'h0, valid_id}, 32'h1);
    check("restart pc",    pc_id, 32'h0040_0000);
    check("restart instr", instr_id, mem_word(32'h0040_0000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
